// File: rtl/bcd_timer_if.sv
// rtl/bcd_timer_if.sv - control and display bundle for bcd_timer; dir_i exists only under BCD_TIMER_COUNTDOWN_EN
interface bcd_timer_if;
   logic       clk_div_i;
   logic       start_i;
   logic       stop_i;
   logic       clear_i;
`ifdef BCD_TIMER_COUNTDOWN_EN
   logic       dir_i;
`endif
   logic [3:0] sec_u_o;
   logic [3:0] sec_t_o;
   logic [3:0] min_u_o;
   logic [3:0] min_t_o;
   logic       running_o;
   logic       roll_o;

`ifdef BCD_TIMER_COUNTDOWN_EN
   modport master (
      output clk_div_i, start_i, stop_i, clear_i, dir_i,
      input  sec_u_o, sec_t_o, min_u_o, min_t_o, running_o, roll_o
   );
   modport slave (
      input  clk_div_i, start_i, stop_i, clear_i, dir_i,
      output sec_u_o, sec_t_o, min_u_o, min_t_o, running_o, roll_o
   );
`else
   modport master (
      output clk_div_i, start_i, stop_i, clear_i,
      input  sec_u_o, sec_t_o, min_u_o, min_t_o, running_o, roll_o
   );
   modport slave (
      input  clk_div_i, start_i, stop_i, clear_i,
      output sec_u_o, sec_t_o, min_u_o, min_t_o, running_o, roll_o
   );
`endif
endinterface

// File: rtl/bcd_timer.sv
// rtl/bcd_timer.sv - MM:SS BCD stopwatch driven by a divided clock; BCD_TIMER_COUNTDOWN_EN adds down counting
// A qualified clk_div_i edge feeds a prescaler whose wrap registers a second-step applied one edge later.
module bcd_timer #(
   parameter int unsigned TICKS_PER_SEC = 1,
   parameter int unsigned MAX_MIN       = 59
) (
   input  logic        clk,
   input  logic        rst,
   bcd_timer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [15:0] PRESC_LAST = 16'(TICKS_PER_SEC - 1);
   localparam logic [3:0]  MAX_MT     = 4'(MAX_MIN / 10);
   localparam logic [3:0]  MAX_MU     = 4'(MAX_MIN % 10);

   state_t      state_q, state_d;
   logic        div_q;
   logic [15:0] presc_q, presc_d;
   logic        step_q, step_d;
   logic        roll_q, roll_d;
   logic [3:0]  su_q, su_d;
   logic [3:0]  st_q, st_d;
   logic [3:0]  mu_q, mu_d;
   logic [3:0]  mt_q, mt_d;

   logic tick;
   logic running;
   logic sec_max;
   logic min_max;
   logic at_zero;
   logic count_down;

`ifdef BCD_TIMER_COUNTDOWN_EN
   assign count_down = bus.dir_i;
`else
   assign count_down = 1'b0;
`endif

   assign tick    = bus.clk_div_i & ~div_q;
   assign running = (state_q == RUN);
   assign sec_max = (st_q == 4'd5) && (su_q == 4'd9);
   assign min_max = (mt_q == MAX_MT) && (mu_q == MAX_MU);
   assign at_zero = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         div_q   <= 1'b0;
         presc_q <= '0;
         step_q  <= 1'b0;
         roll_q  <= 1'b0;
         su_q    <= '0;
         st_q    <= '0;
         mu_q    <= '0;
         mt_q    <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= bus.clk_div_i;
         presc_q <= presc_d;
         step_q  <= step_d;
         roll_q  <= roll_d;
         su_q    <= su_d;
         st_q    <= st_d;
         mu_q    <= mu_d;
         mt_q    <= mt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      step_d  = 1'b0;
      roll_d  = 1'b0;
      su_d    = su_q;
      st_d    = st_q;
      mu_d    = mu_q;
      mt_d    = mt_q;

      if (bus.clear_i) begin
         state_d = IDLE;
         presc_d = '0;
         su_d    = '0;
         st_d    = '0;
         mu_d    = '0;
         mt_d    = '0;
      end else begin
         case (state_q)
            IDLE:    if (bus.start_i) state_d = RUN;
            RUN:     if (bus.stop_i)  state_d = PAUSE;
            PAUSE:   if (bus.start_i) state_d = RUN;
            default: state_d = IDLE;
         endcase

         if (running && tick) begin
            if (presc_q == PRESC_LAST) begin
               presc_d = '0;
               step_d  = 1'b1;
            end else begin
               presc_d = presc_q + 16'd1;
            end
         end

         // A step already issued is applied even if stop arrived in the same cycle.
         if (step_q) begin
            if (count_down) begin
               if (at_zero) begin
                  roll_d  = 1'b1;
                  state_d = IDLE;
                  presc_d = '0;
               end else if (su_q != 4'd0) begin
                  su_d = su_q - 4'd1;
               end else begin
                  su_d = 4'd9;
                  if (st_q != 4'd0) begin
                     st_d = st_q - 4'd1;
                  end else begin
                     st_d = 4'd5;
                     if (mu_q != 4'd0) begin
                        mu_d = mu_q - 4'd1;
                     end else begin
                        mu_d = 4'd9;
                        mt_d = mt_q - 4'd1;
                     end
                  end
               end
            end else if (sec_max && min_max) begin
               su_d   = '0;
               st_d   = '0;
               mu_d   = '0;
               mt_d   = '0;
               roll_d = 1'b1;
            end else if (su_q != 4'd9) begin
               su_d = su_q + 4'd1;
            end else begin
               su_d = 4'd0;
               if (st_q != 4'd5) begin
                  st_d = st_q + 4'd1;
               end else begin
                  st_d = 4'd0;
                  if (mu_q != 4'd9) begin
                     mu_d = mu_q + 4'd1;
                  end else begin
                     mu_d = 4'd0;
                     mt_d = mt_q + 4'd1;
                  end
               end
            end
         end
      end
   end

   assign bus.sec_u_o   = su_q;
   assign bus.sec_t_o   = st_q;
   assign bus.min_u_o   = mu_q;
   assign bus.min_t_o   = mt_q;
   assign bus.running_o = running;
   assign bus.roll_o    = roll_q;

endmodule
